// File: rtl/intl_ext_pkg.sv
// Shared types and constants for the external interlock output driver.
// The heartbeat watchdog is optional and is built only when INTL_EXT_HEARTBEAT_EN is defined.
package intl_ext_pkg;

    localparam int N_CH_DEF    = 4;
    localparam int HOLD_W_DEF  = 20;
    localparam int STATE_W     = 32;
    localparam int TRIP_CNT_W  = 16;
    localparam int POP_W       = 6;

    typedef enum logic [1:0] {
        CH_OK      = 2'd0,
        CH_HOLD    = 2'd1,
        CH_LATCHED = 2'd2
    } ch_state_e;

    function automatic logic [POP_W-1:0] popCount(input logic [STATE_W-1:0] vec);
        logic [POP_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < STATE_W; i++) begin
            sum = sum + POP_W'(vec[i]);
        end
        return sum;
    endfunction

endpackage

// File: rtl/intl_ext_out_ch.sv
// One external interlock channel: OK/HOLD/LATCHED state machine, minimum-hold
// counter, first-cause capture and refused-clear pulse.
module intl_ext_out_ch
    import intl_ext_pkg::*;
#(
    parameter int HOLD_W = HOLD_W_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [STATE_W-1:0]  i_intl_state,
    input  logic [STATE_W-1:0]  i_mask,
    input  logic                i_sw_trip,
    input  logic                i_intl_clr,
    input  logic [HOLD_W-1:0]   i_hold_cycles,
    output logic                o_nintl,
    output logic [1:0]          o_state,
    output logic [STATE_W-1:0]  o_first_cause,
    output logic                o_clr_rej,
    output logic                o_new_trip
);

    ch_state_e            r_state;
    ch_state_e            w_stateNext;
    logic [HOLD_W-1:0]    r_holdCnt;
    logic [HOLD_W-1:0]    r_holdLast;
    logic [STATE_W-1:0]   r_cause;
    logic                 r_clrRej;
    logic                 r_nintl;
    logic                 w_trip;
    logic                 w_load;
    logic                 w_clrRej;

    assign w_trip = (|(i_intl_state & i_mask)) | i_sw_trip;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= CH_LATCHED;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_load      = 1'b0;
        w_clrRej    = 1'b0;
        o_new_trip  = 1'b0;
        case (r_state)
            CH_OK: begin
                if (w_trip) begin
                    w_stateNext = CH_HOLD;
                    w_load      = 1'b1;
                    o_new_trip  = 1'b1;
                end
            end
            CH_HOLD: begin
                if (r_holdCnt == r_holdLast) begin
                    w_stateNext = CH_LATCHED;
                end
            end
            CH_LATCHED: begin
                if (i_intl_clr) begin
                    if (w_trip) begin
                        w_clrRej = 1'b1;
                    end else begin
                        w_stateNext = CH_OK;
                    end
                end
            end
            default: w_stateNext = CH_LATCHED;
        endcase
    end

    // The hold target is stored as "last count value" so a zero request still gives one HOLD cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_holdCnt  <= '0;
            r_holdLast <= '0;
            r_cause    <= '0;
            r_clrRej   <= 1'b0;
            r_nintl    <= 1'b0;
        end else begin
            r_clrRej <= w_clrRej;
            r_nintl  <= (w_stateNext == CH_OK);
            if (w_load) begin
                r_holdCnt  <= '0;
                r_holdLast <= (i_hold_cycles == '0) ? '0 : i_hold_cycles - HOLD_W'(1);
                r_cause    <= i_intl_state & i_mask;
            end else if (r_state == CH_HOLD) begin
                r_holdCnt <= r_holdCnt + HOLD_W'(1);
            end
        end
    end

    assign o_nintl       = r_nintl;
    assign o_state       = r_state;
    assign o_first_cause = r_cause;
    assign o_clr_rej     = r_clrRej;

endmodule

// File: rtl/intl_ext_out.sv
// External interlock output driver: N_CH fail-safe lines driven from the INTL state vector.
// Optional heartbeat watchdog enabled by defining INTL_EXT_HEARTBEAT_EN.
module intl_ext_out
    import intl_ext_pkg::*;
#(
    parameter int N_CH      = N_CH_DEF,
    parameter int HOLD_W    = HOLD_W_DEF,
    parameter int HB_PERIOD = 100000
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [STATE_W-1:0]        i_intl_state,
    input  logic [N_CH*STATE_W-1:0]   i_src_mask,
    input  logic [N_CH-1:0]           i_sw_trip,
    input  logic                      i_intl_clr,
    input  logic [HOLD_W-1:0]         i_hold_cycles,
    output logic [N_CH-1:0]           o_nintl_ext,
    output logic [2*N_CH-1:0]         o_ch_state,
    output logic [N_CH*STATE_W-1:0]   o_first_cause,
    output logic [TRIP_CNT_W-1:0]     o_trip_cnt,
    output logic [N_CH-1:0]           o_clr_rej,
    output logic                      o_heartbeat
);

    logic [N_CH-1:0]        w_newTrips;
    logic [POP_W-1:0]       w_newTripCount;
    logic [TRIP_CNT_W:0]    w_tripSum;
    logic [TRIP_CNT_W-1:0]  r_tripCnt;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        intl_ext_out_ch #(
            .HOLD_W (HOLD_W)
        ) u_ch (
            .i_clk         (i_clk),
            .i_rst         (i_rst),
            .i_intl_state  (i_intl_state),
            .i_mask        (i_src_mask[STATE_W*k +: STATE_W]),
            .i_sw_trip     (i_sw_trip[k]),
            .i_intl_clr    (i_intl_clr),
            .i_hold_cycles (i_hold_cycles),
            .o_nintl       (o_nintl_ext[k]),
            .o_state       (o_ch_state[2*k +: 2]),
            .o_first_cause (o_first_cause[STATE_W*k +: STATE_W]),
            .o_clr_rej     (o_clr_rej[k]),
            .o_new_trip    (w_newTrips[k])
        );
    end

    // Several channels may trip together; each one counts, and the total saturates.
    assign w_newTripCount = popCount(STATE_W'(w_newTrips));
    assign w_tripSum      = {1'b0, r_tripCnt} + (TRIP_CNT_W+1)'(w_newTripCount);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tripCnt <= '0;
        end else begin
            r_tripCnt <= w_tripSum[TRIP_CNT_W] ? {TRIP_CNT_W{1'b1}} : w_tripSum[TRIP_CNT_W-1:0];
        end
    end

    assign o_trip_cnt = r_tripCnt;

`ifdef INTL_EXT_HEARTBEAT_EN
    logic [31:0] r_hbCnt;
    logic        r_hb;
    logic        w_allOk;

    assign w_allOk = &o_nintl_ext;

    // Heartbeat only runs while every line is healthy, so a stuck-low pin also stops the toggle.
    always_ff @(posedge i_clk) begin
        if (i_rst || !w_allOk) begin
            r_hbCnt <= '0;
            r_hb    <= 1'b0;
        end else if (r_hbCnt == 32'(HB_PERIOD - 1)) begin
            r_hbCnt <= '0;
            r_hb    <= ~r_hb;
        end else begin
            r_hbCnt <= r_hbCnt + 32'd1;
        end
    end

    assign o_heartbeat = r_hb;
`else
    assign o_heartbeat = 1'b0;
`endif

endmodule

// File: tb/tb_intl_ext_out.sv
// Table-driven scoreboard bench for intl_ext_out (4 channels, channel 0 masked on state bit 0).
module tb_intl_ext_out;

    localparam int N_CH   = 4;
    localparam int HOLD_W = 20;

    typedef struct {
        logic        rst;
        logic [31:0] st;
        logic [31:0] mask0;
        logic [3:0]  sw;
        logic        clr;
        logic [19:0] hold;
        int          cyc;
        logic [3:0]  nintl;
        logic [7:0]  chState;
        logic [3:0]  rej;
        logic [15:0] cnt;
        logic [31:0] cause0;
    } vec_t;

    logic                   clk;
    logic                   rst;
    logic [31:0]            intlState;
    logic [N_CH*32-1:0]     srcMask;
    logic [N_CH-1:0]        swTrip;
    logic                   intlClr;
    logic [HOLD_W-1:0]      holdCycles;
    logic [N_CH-1:0]        nintlExt;
    logic [2*N_CH-1:0]      chState;
    logic [N_CH*32-1:0]     firstCause;
    logic [15:0]            tripCnt;
    logic [N_CH-1:0]        clrRej;
    logic                   heartbeat;

    int   checks = 0;
    int   errors = 0;
    vec_t expQ[$];
    vec_t tbl[16];

    intl_ext_out #(
        .N_CH      (N_CH),
        .HOLD_W    (HOLD_W),
        .HB_PERIOD (8)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_intl_state  (intlState),
        .i_src_mask    (srcMask),
        .i_sw_trip     (swTrip),
        .i_intl_clr    (intlClr),
        .i_hold_cycles (holdCycles),
        .o_nintl_ext   (nintlExt),
        .o_ch_state    (chState),
        .o_first_cause (firstCause),
        .o_trip_cnt    (tripCnt),
        .o_clr_rej     (clrRej),
        .o_heartbeat   (heartbeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic [31:0] s, logic [31:0] m, logic [3:0] w, logic c,
                                logic [19:0] h, int n, logic [3:0] ni, logic [7:0] cs,
                                logic [3:0] rj, logic [15:0] ct, logic [31:0] ca);
        vec_t v;
        v.rst = r; v.st = s; v.mask0 = m; v.sw = w; v.clr = c; v.hold = h; v.cyc = n;
        v.nintl = ni; v.chState = cs; v.rej = rj; v.cnt = ct; v.cause0 = ca;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic driveInputs(input vec_t v);
        rst        = v.rst;
        intlState  = v.st;
        srcMask    = {96'd0, v.mask0};
        swTrip     = v.sw;
        intlClr    = v.clr;
        holdCycles = v.hold;
    endtask

    task automatic checkOutput();
        vec_t e;
        if (expQ.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = expQ.pop_front();
            check("nintl_ext", 32'(nintlExt), 32'(e.nintl));
            check("ch_state", 32'(chState), 32'(e.chState));
            check("clr_rej", 32'(clrRej), 32'(e.rej));
            check("trip_cnt", 32'(tripCnt), 32'(e.cnt));
            check("first_cause0", firstCause[31:0], e.cause0);
`ifndef INTL_EXT_HEARTBEAT_EN
            check("heartbeat", 32'(heartbeat), 32'd0);
`endif
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        for (int c = 0; c < v.cyc; c++) begin
            @(negedge clk);
            driveInputs(v);
            expQ.push_back(v);
            @(posedge clk);
            #1;
            checkOutput();
        end
    endtask

    task automatic driveRaw(input logic [31:0] s, input logic [3:0] w, input logic c, input logic [19:0] h);
        @(negedge clk);
        rst = 1'b0; intlState = s; srcMask = {96'd0, 32'h1}; swTrip = w; intlClr = c; holdCycles = h;
    endtask

    initial begin
        rst = 1'b1; intlState = '0; srcMask = '0; swTrip = '0; intlClr = 1'b0; holdCycles = '0;

        //             rst st      mask0   sw    clr hold cyc nintl  state  rej   cnt     cause0
        tbl[0]  = mk(1, 32'h0, 32'h1, 4'h0, 0, 10, 2, 4'h0, 8'hAA, 4'h0, 16'd0, 32'h0);
        tbl[1]  = mk(0, 32'h0, 32'h1, 4'h0, 1, 10, 1, 4'hF, 8'h00, 4'h0, 16'd0, 32'h0);
        tbl[2]  = mk(0, 32'h1, 32'h1, 4'h0, 0, 10, 2, 4'hE, 8'h01, 4'h0, 16'd1, 32'h1);
        tbl[3]  = mk(0, 32'h0, 32'h1, 4'h0, 1, 10, 1, 4'hE, 8'h01, 4'h0, 16'd1, 32'h1);
        tbl[4]  = mk(0, 32'h0, 32'h1, 4'h0, 0, 10, 7, 4'hE, 8'h01, 4'h0, 16'd1, 32'h1);
        tbl[5]  = mk(0, 32'h0, 32'h1, 4'h0, 0, 10, 1, 4'hE, 8'h02, 4'h0, 16'd1, 32'h1);
        tbl[6]  = mk(0, 32'h0, 32'h1, 4'h0, 1, 10, 1, 4'hF, 8'h00, 4'h0, 16'd1, 32'h1);
        tbl[7]  = mk(0, 32'h1, 32'h1, 4'h0, 0, 0,  1, 4'hE, 8'h01, 4'h0, 16'd2, 32'h1);
        tbl[8]  = mk(0, 32'h1, 32'h1, 4'h0, 0, 10, 1, 4'hE, 8'h02, 4'h0, 16'd2, 32'h1);
        tbl[9]  = mk(0, 32'h1, 32'h1, 4'h0, 1, 10, 1, 4'hE, 8'h02, 4'h1, 16'd2, 32'h1);
        tbl[10] = mk(0, 32'h1, 32'h1, 4'h0, 0, 10, 1, 4'hE, 8'h02, 4'h0, 16'd2, 32'h1);
        tbl[11] = mk(0, 32'h0, 32'h1, 4'hA, 0, 0,  1, 4'h4, 8'h46, 4'h0, 16'd4, 32'h1);
        tbl[12] = mk(0, 32'h0, 32'h1, 4'h0, 1, 0,  1, 4'h5, 8'h88, 4'h0, 16'd4, 32'h1);
        tbl[13] = mk(0, 32'h0, 32'h1, 4'h0, 1, 0,  1, 4'hF, 8'h00, 4'h0, 16'd4, 32'h1);
        tbl[14] = mk(0, 32'h1, 32'h0, 4'h0, 0, 0,  1, 4'hF, 8'h00, 4'h0, 16'd4, 32'h1);
        tbl[15] = mk(0, 32'h0, 32'h1, 4'h0, 0, 0,  1, 4'hF, 8'h00, 4'h0, 16'd4, 32'h1);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(tbl[i]);
        end

        // Drive the trip counter up to 65532 with four simultaneous trips per round.
        for (int i = 0; i < 16382; i++) begin
            driveRaw(32'h0, 4'hF, 1'b0, 20'd0);
            driveRaw(32'h0, 4'h0, 1'b0, 20'd0);
            driveRaw(32'h0, 4'h0, 1'b1, 20'd0);
        end
        applyStimulus(mk(0, 32'h0, 32'h1, 4'hA, 0, 0,  1, 4'h5, 8'h44, 4'h0, 16'd65534, 32'h0));
        applyStimulus(mk(0, 32'h0, 32'h1, 4'h0, 0, 0,  1, 4'h5, 8'h88, 4'h0, 16'd65534, 32'h0));
        applyStimulus(mk(0, 32'h0, 32'h1, 4'h0, 1, 0,  1, 4'hF, 8'h00, 4'h0, 16'd65534, 32'h0));
        applyStimulus(mk(0, 32'h1, 32'h1, 4'hE, 0, 10, 1, 4'h0, 8'h55, 4'h0, 16'hFFFF, 32'h1));
        applyStimulus(mk(0, 32'h0, 32'h1, 4'h0, 0, 10, 1, 4'h0, 8'h55, 4'h0, 16'hFFFF, 32'h1));
        applyStimulus(mk(1, 32'h0, 32'h1, 4'h0, 0, 10, 1, 4'h0, 8'hAA, 4'h0, 16'd0, 32'h0));
        check("first_cause_all_reset", 32'(|firstCause), 32'd0);
        applyStimulus(mk(0, 32'h0, 32'h1, 4'h0, 1, 10, 1, 4'hF, 8'h00, 4'h0, 16'd0, 32'h0));

`ifdef INTL_EXT_HEARTBEAT_EN
        begin
            int  waitCyc;
            int  period;
            logic prev;
            waitCyc = 0;
            prev = heartbeat;
            while (heartbeat == prev && waitCyc < 40) begin
                @(posedge clk); #1; waitCyc++;
            end
            check("hb_first_toggle_seen", 32'(waitCyc < 40), 32'd1);
            prev = heartbeat;
            period = 0;
            while (heartbeat == prev && period < 40) begin
                @(posedge clk); #1; period++;
            end
            check("hb_period", 32'(period), 32'd8);
            driveRaw(32'h0, 4'h1, 1'b0, 20'd5);
            @(posedge clk); #1;
            @(posedge clk); #1;
            check("hb_drop_on_trip", 32'(heartbeat), 32'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/intl_ext_out.md
# intl_ext_out

External interlock output driver: the transmit side of the MPS interlock path. It takes the 32-bit interlock state vector produced by the INTL block and maps it onto N_CH fail-safe external interlock lines (`o_nintl_ext`, high = healthy, low = tripped). Each line has a per-channel source mask, a software-forced trip, a minimum trip hold time and a latched-until-clear policy. The block sits in INTL_Top beside INTL, is configured from the AXI4-Lite register file, and drives the board's external interlock output pins.

## Interface
- N_CH, 4, number of external interlock output channels
- HOLD_W, 20, width of the minimum-hold counter
- HB_PERIOD, 100000, heartbeat half-period in clocks (used only with the heartbeat feature)
- i_clk  in  1  system clock (s00_axi_aclk domain)
- i_rst  in  1  reset, synchronous, active-high
- i_intl_state  in  32  interlock state vector from INTL
- i_src_mask  in  N_CH*32  per-channel source enables; channel k uses bits [32k+31:32k]
- i_sw_trip  in  N_CH  level-sensitive software-forced trip per channel
- i_intl_clr  in  1  single-cycle clear pulse
- i_hold_cycles  in  HOLD_W  minimum tripped time in clocks
- o_nintl_ext  out  N_CH  external interlock lines; 1 = OK, 0 = trip
- o_ch_state  out  2*N_CH  per-channel state encoding
- o_first_cause  out  N_CH*32  masked state captured at trip entry
- o_trip_cnt  out  16  saturating count of OK→HOLD transitions, all channels
- o_clr_rej  out  N_CH  one-cycle pulse: a clear was refused
- o_heartbeat  out  1  watchdog toggle

## Operation
- Trip term per channel: t_k = |(i_intl_state & mask_k) | i_sw_trip[k].
- States per channel, with o_ch_state encoding: OK=2'd0, HOLD=2'd1, LATCHED=2'd2.
- OK:
  - o_nintl_ext[k]=1.
  - If t_k: go to HOLD, load hold counter with 0, capture i_intl_state & mask_k into o_first_cause[k], increment o_trip_cnt (saturates at 16'hFFFF).
  - i_intl_clr is ignored.
- HOLD:
  - o_nintl_ext[k]=0; counter increments every cycle.
  - i_hold_cycles is sampled once, on entry.
  - Stay max(i_hold_cycles,1) cycles, then go to LATCHED regardless of t_k.
  - Clear is ignored; no o_clr_rej pulse.
- LATCHED:
  - o_nintl_ext[k]=0.
  - i_intl_clr with t_k=0: go to OK.
  - i_intl_clr with t_k=1: stay in LATCHED and pulse o_clr_rej[k] for one cycle.
- Several channels tripping in the same cycle each add to o_trip_cnt; the counter adds the popcount of new trips that cycle, saturating.
- o_first_cause[k] holds its value until the next OK→HOLD transition of channel k.

## Timing
- All outputs are registered.
- Trip latency: t_k high at cycle n gives o_nintl_ext[k]=0 and state HOLD at n+1.
- Clear latency: accepted i_intl_clr at cycle m gives o_nintl_ext[k]=1 at m+1.
- o_clr_rej is asserted at m+1 for exactly one cycle.
- Reset values: every channel LATCHED, o_nintl_ext=0, o_first_cause=0, o_trip_cnt=0, o_clr_rej=0, o_heartbeat=0. Lines come up fail-safe and need one clear after boot.
- Reset mid-HOLD: the counter is discarded and the channel goes to LATCHED.
- A trip that ends during HOLD does not shorten the hold.
- Mask changes take effect the next cycle, with no retroactive cause update.

## Configuration
- INTL_EXT_HEARTBEAT_EN defined:
  - o_heartbeat toggles every HB_PERIOD clocks while all channels are OK.
  - It holds at 0 and its counter resets while any channel is not OK.
- INTL_EXT_HEARTBEAT_EN undefined: o_heartbeat is tied to 0, no counter is built, and HB_PERIOD is unused.

## Structure
- Package `intl_ext_pkg`:
  - channel-state enum (OK/HOLD/LATCHED with the codes above)
  - N_CH default
  - counter-width constants
- Sub-module `intl_ext_out_ch`:
  - one channel: FSM, hold counter, cause capture, o_clr_rej
  - instantiated N_CH times by a generate loop
  - trip counter and heartbeat stay in the top.

## Test plan
- After reset, expect o_nintl_ext=4'b0000. Pulse i_intl_clr with all sources 0; expect 4'b1111 one cycle later.
- mask_0=32'h1, i_hold_cycles=10, i_intl_state=32'h1 for 2 cycles: ch0 is low for at least 10 cycles. Clear at cycle 5 is ignored. Clear after LATCHED restores ch0 to 1, and o_first_cause[0]=32'h1.
- In LATCHED with i_intl_state=32'h1 still present, pulse clear: o_clr_rej[0] pulses once and o_nintl_ext[0] stays 0.
- i_sw_trip=4'b1010 in one cycle: channels 1 and 3 trip, and o_trip_cnt increments by 2. Preset the count near 16'hFFFF and check it saturates.
- i_hold_cycles=0: HOLD lasts exactly 1 cycle. Assert reset mid-HOLD: the channel goes to LATCHED and all outputs return to their reset values.
- Heartbeat build with HB_PERIOD=8, all channels OK: o_heartbeat toggles every 8 cycles. It drops to 0 within one cycle of any trip.
